// File: rtl/result_uart_logger.sv
// result_uart_logger: buffers classifier results in a small FIFO and sends
// each as one UART byte (8N1, or 8E1 when LOGGER_PARITY_EN is defined).
// Ports: clk_25m, rst_n (async active-low), enable, result, result_valid,
// restart in; tx (idle high), busy, send_done, drop_cnt[7:0] out.
module result_uart_logger #(
  parameter int CLASS_W   = 4,
  parameter int MAX_COUNT = 101,
  parameter int FIFO_AW   = 4,
  parameter int BAUD_DIV  = 217
) (
  input  logic               clk_25m,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [CLASS_W-1:0] result,
  input  logic               result_valid,
  input  logic               restart,
  output logic               tx,
  output logic               busy,
  output logic               send_done,
  output logic [7:0]         drop_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(BAUD_DIV);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t state, state_nx;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic [7:0]         count;
  logic [BW-1:0]      baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic [7:0]         din, pop_data;
  logic               empty, full;
  logic               attempt, push, pop_base, pop;
  logic               baud_tick, stop_end;
  logic               tx_nx;

  assign din       = 8'(result);
  assign empty     = (level == '0);
  assign full      = (level == (FIFO_AW+1)'(DEPTH));
  assign baud_tick = (state != IDLE) &&
                     (baud_cnt == BW'(BAUD_DIV - 1));
  assign stop_end  = (state == STOP) && baud_tick;
  assign attempt   = result_valid & enable &
                     ~send_done & ~restart;

  // A pop in the same cycle frees a slot, so a full
  // FIFO still accepts when the transmitter drains it.
  assign pop_base  = ~empty & ((state == IDLE) | stop_end);
  assign push      = attempt & (~full | pop_base);

  // Frame ending with an empty FIFO takes the
  // incoming byte straight through (bypass).
  assign pop       = pop_base | (stop_end & push);
  assign pop_data  = empty ? din : mem[rd_ptr];

  assign busy      = (state != IDLE) | ~empty;

  always_ff @(posedge clk_25m) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (FIFO_AW+1)'(push)
                     - (FIFO_AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      send_done <= 1'b0;
      drop_cnt  <= '0;
    end else if (restart) begin
      count     <= '0;
      send_done <= 1'b0;
      drop_cnt  <= '0;
    end else if (push) begin
      count     <= count + 8'd1;
      send_done <= (count + 8'd1 == 8'(MAX_COUNT));
    end else if (attempt && drop_cnt != 8'hff) begin
      drop_cnt  <= drop_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    tx_nx    = 1'b1;
    unique case (state)
      IDLE: begin
        if (pop) state_nx = START;
      end
      START: begin
        tx_nx = 1'b0;
        if (baud_tick) state_nx = DATA;
      end
      DATA: begin
        tx_nx = shreg[bit_idx];
        if (baud_tick && bit_idx == 3'd7) begin
`ifdef LOGGER_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef LOGGER_PARITY_EN
      PARITY: begin
        tx_nx = ^shreg;
        if (baud_tick) state_nx = STOP;
      end
`endif
      STOP: begin
        if (baud_tick) state_nx = pop ? START : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state <= state_nx;
      tx    <= tx_nx;
      if (pop) shreg <= pop_data;
      // Bit timing restarts on every state entry.
      if (state == IDLE || baud_tick || state_nx != state)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;
      if (state != DATA)
        bit_idx <= '0;
      else if (baud_tick)
        bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_result_uart_logger.sv
// tb_result_uart_logger: two logger instances (MAX_COUNT 3 and 101,
// 4-deep FIFO, 8 clocks/bit) against a timeline model of frames.
module tb_result_uart_logger;

  localparam int B = 8;
`ifdef LOGGER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * B;
  localparam int DEP = 4;

  logic clk_25m = 1'b0;
  always #20 clk_25m = ~clk_25m;

  logic       rst_n, enable, result_valid, restart;
  logic [3:0] result;
  logic       tx_a, busy_a, sd_a;
  logic       tx_b, busy_b, sd_b;
  logic [7:0] drop_a, drop_b;

  result_uart_logger #(
    .CLASS_W(4), .MAX_COUNT(3),
    .FIFO_AW(2), .BAUD_DIV(B)
  ) dut_a (
    .clk_25m(clk_25m), .rst_n(rst_n),
    .enable(enable), .result(result),
    .result_valid(result_valid),
    .restart(restart), .tx(tx_a),
    .busy(busy_a), .send_done(sd_a),
    .drop_cnt(drop_a)
  );

  result_uart_logger #(
    .CLASS_W(4), .MAX_COUNT(101),
    .FIFO_AW(2), .BAUD_DIV(B)
  ) dut_b (
    .clk_25m(clk_25m), .rst_n(rst_n),
    .enable(enable), .result(result),
    .result_valid(result_valid),
    .restart(restart), .tx(tx_b),
    .busy(busy_b), .send_done(sd_b),
    .drop_cnt(drop_b)
  );

  int npass = 0;
  int nfail = 0;
  int nchk  = 0;
  int t     = 0;

  int         maxc [2] = '{3, 101};
  int         m_cnt [2];
  int         m_occ [2];
  int         m_rd  [2];
  int         m_pe  [2];
  int         m_drop [2];
  logic       m_sd  [2];
  logic [7:0] m_fifo [2][DEP];
  logic [7:0] m_cur [2];
  logic       e_tx  [2];
  logic       e_busy [2];
  logic       prev_a, prev_b;
  int         rises_a, rises_b;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h",
             tag, t, obs, exp);
    end
  endtask

  // Line level seen after edge tt for the frame popped at m_pe.
  function automatic logic tx_at(int i, int tt);
    int k;
    if (m_pe[i] >= 0 && tt > m_pe[i] && tt <= m_pe[i] + F) begin
      k = (tt - 1 - m_pe[i]) / B;
      if (k == 0) return 1'b0;
      if (k <= 8) return m_cur[i][k-1];
      if (k == 9 && NB == 11) return ^m_cur[i];
      return 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_occ[i] = 0; m_rd[i] = 0;
      m_pe[i] = -1000; m_drop[i] = 0; m_sd[i] = 1'b0;
      m_cur[i] = 8'h00;
      e_tx[i] = 1'b1; e_busy[i] = 1'b0;
    end
  endtask

  task automatic model_edge(int i);
    bit active, ending, cond, pbase, push, pop;
    int occ0;
    active = (m_pe[i] >= 0) && (t > m_pe[i]) && (t <= m_pe[i] + F);
    ending = active && (t == m_pe[i] + F);
    e_tx[i] = tx_at(i, t);
    cond  = result_valid && enable && !m_sd[i] && !restart;
    pbase = (!active || ending) && m_occ[i] > 0;
    push  = cond && (m_occ[i] < DEP || pbase);
    pop   = pbase || (ending && push);
    if (restart) begin
      m_cnt[i] = 0; m_sd[i] = 1'b0; m_drop[i] = 0;
    end else if (push) begin
      m_cnt[i]++;
      m_sd[i] = (m_cnt[i] == maxc[i]);
    end else if (cond && m_drop[i] < 255) begin
      m_drop[i]++;
    end
    occ0 = m_occ[i];
    if (pop && occ0 > 0) begin
      m_cur[i] = m_fifo[i][m_rd[i]];
      m_rd[i] = (m_rd[i] + 1) % DEP;
      m_occ[i]--;
    end
    if (push) begin
      m_fifo[i][(m_rd[i] + m_occ[i]) % DEP] = 8'(result);
      m_occ[i]++;
    end
    if (pop && occ0 == 0) begin
      m_cur[i] = m_fifo[i][m_rd[i]];
      m_rd[i] = (m_rd[i] + 1) % DEP;
      m_occ[i]--;
    end
    if (pop) m_pe[i] = t;
    e_busy[i] = pop || (active && !ending) || m_occ[i] > 0;
  endtask

  task automatic check_all();
    chk("tx_a", tx_a, e_tx[0]);
    chk("busy_a", busy_a, e_busy[0]);
    chk("send_done_a", sd_a, m_sd[0]);
    chk("drop_a", drop_a, m_drop[0]);
    chk("tx_b", tx_b, e_tx[1]);
    chk("busy_b", busy_b, e_busy[1]);
    chk("send_done_b", sd_b, m_sd[1]);
    chk("drop_b", drop_b, m_drop[1]);
  endtask

  task automatic cyc();
    @(posedge clk_25m);
    t++;
    if (!rst_n) model_reset();
    else begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_all();
    if (busy_a && !prev_a) rises_a++;
    if (busy_b && !prev_b) rises_b++;
    prev_a = busy_a;
    prev_b = busy_b;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic strobe(logic [3:0] v);
    result = v;
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
  endtask

  int pe0;

  initial begin
    rst_n = 1'b0; enable = 1'b1; result_valid = 1'b0;
    restart = 1'b0; result = 4'h0;
    prev_a = 1'b0; prev_b = 1'b0; rises_a = 0; rises_b = 0;
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(3);

    // Single byte 0x05 and its start-bit latency.
    strobe(4'h5);
    cyc();
    chk("lat_tx_idle", tx_a, 1'b1);
    cyc();
    chk("lat_tx_start", tx_a, 1'b0);
    idle(F + 10);
    chk("single_busy_low", busy_a, 1'b0);
    pulse_restart();

    // MAX_COUNT=3 on dut_a, five spaced strobes.
    rises_a = 0;
    for (int k = 0; k < 5; k++) begin
      strobe(4'($urandom));
      idle(100);
    end
    chk("three_frames", rises_a, 3);
    chk("sd_after_3", sd_a, 1'b1);
    chk("sd_drop0", drop_a, 8'd0);

    // Restart together with a strobe: strobe dropped silently.
    restart = 1'b1;
    result_valid = 1'b1;
    result = 4'hA;
    cyc();
    restart = 1'b0;
    result_valid = 1'b0;
    chk("rst_sd_clr", sd_a, 1'b0);
    chk("rst_no_push", busy_a, 1'b0);
    strobe(4'h3);
    chk("post_rst_accept", busy_a, 1'b1);
    idle(F + 10);

    // Ten back-to-back strobes into a 4-deep FIFO.
    pulse_restart();
    for (int k = 0; k < 10; k++) strobe(4'($urandom));
    chk("burst_drop_range",
        (drop_b == 8'd5 || drop_b == 8'd6), 1'b1);
    idle(6 * F);

    // Reset during data bit 3.
    pulse_restart();
    strobe(4'hF);
    cyc();
    pe0 = t;
    while (t < pe0 + 1 + 4 * B + 3) cyc();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_tx_a", tx_a, 1'b1);
    chk("arst_busy_a", busy_a, 1'b0);
    chk("arst_tx_b", tx_b, 1'b1);
    idle(3);
    rst_n = 1'b1;
    rises_a = 0;
    idle(2 * F);
    chk("no_resume", rises_a, 0);

    // Gate closed: everything ignored.
    enable = 1'b0;
    rises_b = 0;
    for (int k = 0; k < 20; k++) begin
      strobe(4'($urandom));
      cyc();
    end
    chk("gated_frames", rises_b, 0);
    chk("gated_drop", drop_b, 8'd0);
    enable = 1'b1;

    // Drop counter saturation.
    pulse_restart();
    result_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      result = 4'($urandom);
      cyc();
    end
    result_valid = 1'b0;
    chk("drop_sat", drop_b, 8'd255);
    idle(6 * F);

    // Random traffic.
    pulse_restart();
    for (int k = 0; k < 1500; k++) begin
      result = 4'($urandom);
      result_valid = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 7) != 0);
      restart = ($urandom_range(0, 39) == 0);
      cyc();
    end
    result_valid = 1'b0;
    restart = 1'b0;
    enable = 1'b1;
    idle(6 * F);
    chk("final_idle_b", busy_b, 1'b0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
